// File: rtl/lsu_pkg.sv
// lsu_pkg - shared definitions for the load/store unit.
//   lsu_size_e     : access size encoding (byte/half/word/double)
//   lsu_state_e    : load/store FSM states
//   LSU_ADDR_LIMIT : default byte size of the attached data memory
package lsu_pkg;

    localparam int LSU_ADDR_LIMIT = 2048;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align - combinational big-endian extract/extend and store merge.
// Ports:
//   word        in  64  memory word; the byte at the access address is word[63:56]
//   size        in  2   access size (lsu_size_e encoding)
//   is_unsigned in  1   zero-extend loads when 1, sign-extend when 0
//   wdata       in  64  right-aligned store data
//   load_data   out 64  extended load result
//   store_word  out 64  word with its top n bytes replaced by wdata[8n-1:0]
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] word,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_word
);

    always_comb begin
        load_data  = word;
        store_word = wdata;
        case (lsu_size_e'(size))
            SIZE_BYTE: begin
                load_data  = {{56{~is_unsigned & word[63]}}, word[63:56]};
                store_word = {wdata[7:0], word[55:0]};
            end
            SIZE_HALF: begin
                load_data  = {{48{~is_unsigned & word[63]}}, word[63:48]};
                store_word = {wdata[15:0], word[47:0]};
            end
            SIZE_WORD: begin
                load_data  = {{32{~is_unsigned & word[63]}}, word[63:32]};
                store_word = {wdata[31:0], word[31:0]};
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit - single-outstanding load/store unit in front of a
// combinational-read, clocked-write 64-bit data memory.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            core request handshake
//   req_write, req_size, req_unsigned, req_addr, req_wdata  request fields
//   resp_valid/resp_ready          response handshake
//   resp_rdata, resp_error         response payload
//   mem_addr, mem_wdata, mem_write, mem_rdata  data-memory port
// Build option: define LSU_ALIGN_CHECK_EN to reject misaligned accesses.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | accepting a request; error checks made on the request fields
// ST_READ  | mem_addr driven, memory word captured (loads and sub-double stores)
// ST_WRITE | one-cycle mem_write of the merged word
// ST_RESP  | response held until resp_ready
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_LIMIT = LSU_ADDR_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_write,
    input  logic [63:0] mem_rdata
);

    lsu_state_e  state, state_nxt;
    logic        r_write, r_unsigned, resp_error_q;
    logic [1:0]  r_size;
    logic [63:0] r_addr, r_wdata, cap_word, resp_rdata_q;
    logic [63:0] align_word, load_data, store_word;
    logic        range_err, misalign, req_err, accept;

    // The memory always returns 8 bytes, so the whole span must fit.
    assign range_err = req_addr > 64'(ADDR_LIMIT - 8);

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        case (lsu_size_e'(req_size))
            SIZE_HALF:   misalign = req_addr[0];
            SIZE_WORD:   misalign = |req_addr[1:0];
            SIZE_DOUBLE: misalign = |req_addr[2:0];
            default:     misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign req_err = range_err | misalign;
    assign accept  = (state == ST_IDLE) && req_valid;

    // Extraction reads the live memory word in READ; merging uses the captured one.
    assign align_word = (state == ST_READ) ? mem_rdata : cap_word;

    lsu_align u_align (
        .word        (align_word),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .wdata       (r_wdata),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= 64'd0;
            r_wdata      <= 64'd0;
            cap_word     <= 64'd0;
            resp_rdata_q <= 64'd0;
            resp_error_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_write      <= req_write;
                r_unsigned   <= req_unsigned;
                r_size       <= req_size;
                r_addr       <= req_addr;
                r_wdata      <= req_wdata;
                resp_rdata_q <= 64'd0;
                resp_error_q <= req_err;
            end
            if (state == ST_READ) begin
                cap_word <= mem_rdata;
                if (!r_write) begin
                    resp_rdata_q <= load_data;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = 64'd0;
        mem_wdata  = 64'd0;
        mem_write  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_nxt = ST_RESP;
                    else if (req_write && (lsu_size_e'(req_size) == SIZE_DOUBLE))
                        state_nxt = ST_WRITE;
                    else
                        state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                mem_addr  = r_addr;
                state_nxt = r_write ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                mem_addr  = r_addr;
                mem_wdata = store_word;
                mem_write = 1'b1;
                state_nxt = ST_RESP;
            end
            default: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = ST_IDLE;
            end
        endcase
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_write;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:2047];

    load_store_unit #(.ADDR_LIMIT(2048)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Big-endian memory model: byte at mem_addr is the most significant.
    always_comb begin
        mem_rdata = 64'd0;
        for (int i = 0; i < 8; i++)
            mem_rdata[63-8*i -: 8] = mem[(mem_addr[10:0] + 11'(i)) & 11'h7ff];
    end

    always @(posedge clk) begin
        if (mem_write)
            for (int i = 0; i < 8; i++)
                mem[(mem_addr[10:0] + 11'(i)) & 11'h7ff] <= mem_wdata[63-8*i -: 8];
    end

    // Issues one request and waits for its response. Cycle numbers count
    // falling edges after the accept edge (1 = the cycle right after accept).
    task automatic do_access(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wd,
                             output logic [63:0] rdata, output logic err,
                             output int resp_k, output int wr_k, output int wr_n);
        resp_k = -1; wr_k = -1; wr_n = 0; rdata = 'x; err = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_write) begin
                if (wr_k < 0) wr_k = k;
                wr_n++;
            end
            if (resp_valid) begin
                resp_k = k; rdata = resp_rdata; err = resp_error;
                break;
            end
        end
        if (resp_k < 0) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: no resp_valid within 20 cycles (addr %0d)", addr);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({req_ready, resp_valid, mem_write, resp_error} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready/valid/wr/err=%b, want 1000",
                     {req_ready, resp_valid, mem_write, resp_error});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, resp_rdata} !== 192'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, want all 0",
                     mem_addr, mem_wdata, resp_rdata);
        end
    endtask

    task automatic test_load_double();
        logic [63:0] rd; logic er; int rk, wk, wn;
        do_access(1'b0, 2'd3, 1'b0, 64'd0, 64'd0, rd, er, rk, wk, wn);
        n_checks++;
        if (rd !== 64'd8 || er !== 1'b0 || rk != 2 || wn != 0) begin
            n_fail++;
            $display("FAIL load_double0: rdata=%h err=%b resp_k=%0d writes=%0d, want 8/0/2/0",
                     rd, er, rk, wn);
        end
    endtask

    task automatic test_store_half();
        logic [63:0] rd; logic er; int rk, wk, wn;
        do_access(1'b1, 2'd1, 1'b0, 64'd16, 64'h1111_2222_3333_BEEF, rd, er, rk, wk, wn);
        n_checks++;
        if (wk != 2 || wn != 1 || rk != 3 || er !== 1'b0 || rd !== 64'd0) begin
            n_fail++;
            $display("FAIL store_half: wr_k=%0d writes=%0d resp_k=%0d err=%b rdata=%h, want 2/1/3/0/0",
                     wk, wn, rk, er, rd);
        end
        do_access(1'b0, 2'd3, 1'b0, 64'd16, 64'd0, rd, er, rk, wk, wn);
        n_checks++;
        if (rd !== 64'hBEEF_0000_0000_0000) begin
            n_fail++;
            $display("FAIL load_after_half: rdata=%h, want beef000000000000", rd);
        end
    endtask

    task automatic test_extend();
        logic [63:0] rd; logic er; int rk, wk, wn;
        logic [63:0] exp_tab [4];
        logic [1:0]  sz_tab  [4];
        logic        uns_tab [4];
        exp_tab = '{64'hFFFF_FFFF_FFFF_FFBE, 64'h0000_0000_0000_00BE,
                    64'hFFFF_FFFF_FFFF_BEEF, 64'h0000_0000_BEEF_0000};
        sz_tab  = '{2'd0, 2'd0, 2'd1, 2'd2};
        uns_tab = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, sz_tab[i], uns_tab[i], 64'd16, 64'd0, rd, er, rk, wk, wn);
            n_checks++;
            if (rd !== exp_tab[i] || er !== 1'b0) begin
                n_fail++;
                $display("FAIL extend_%0d: rdata=%h err=%b, want %h/0", i, rd, er, exp_tab[i]);
            end
        end
    endtask

    task automatic test_store_merge();
        logic [63:0] rd; logic er; int rk, wk, wn;
        do_access(1'b1, 2'd3, 1'b0, 64'd32, 64'h0123_4567_89AB_CDEF, rd, er, rk, wk, wn);
        n_checks++;
        if (wk != 1 || wn != 1 || rk != 2 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL store_double: wr_k=%0d writes=%0d resp_k=%0d err=%b, want 1/1/2/0",
                     wk, wn, rk, er);
        end
        do_access(1'b0, 2'd2, 1'b0, 64'd36, 64'd0, rd, er, rk, wk, wn);
        n_checks++;
        if (rd !== 64'hFFFF_FFFF_89AB_CDEF) begin
            n_fail++;
            $display("FAIL load_word36: rdata=%h, want ffffffff89abcdef", rd);
        end
        do_access(1'b1, 2'd0, 1'b0, 64'd33, 64'hFFFF_FFFF_FFFF_FF5A, rd, er, rk, wk, wn);
        do_access(1'b0, 2'd3, 1'b0, 64'd32, 64'd0, rd, er, rk, wk, wn);
        n_checks++;
        if (rd !== 64'h015A_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL store_byte_merge: rdata=%h, want 015a456789abcdef", rd);
        end
    endtask

    task automatic test_range();
        logic [63:0] rd; logic er; int rk, wk, wn;
        do_access(1'b0, 2'd3, 1'b0, 64'd2044, 64'd0, rd, er, rk, wk, wn);
        n_checks++;
        if (er !== 1'b1 || rk != 1 || wn != 0 || rd !== 64'd0) begin
            n_fail++;
            $display("FAIL range_2044: err=%b resp_k=%0d writes=%0d rdata=%h, want 1/1/0/0",
                     er, rk, wn, rd);
        end
        do_access(1'b0, 2'd3, 1'b0, 64'd2040, 64'd0, rd, er, rk, wk, wn);
        n_checks++;
        if (er !== 1'b0 || rk != 2) begin
            n_fail++;
            $display("FAIL range_2040: err=%b resp_k=%0d, want 0/2", er, rk);
        end
        do_access(1'b1, 2'd0, 1'b0, 64'd2041, 64'hAA, rd, er, rk, wk, wn);
        n_checks++;
        if (er !== 1'b1 || wn != 0 || rk != 1 || mem[2041] !== 8'h00) begin
            n_fail++;
            $display("FAIL range_store: err=%b writes=%0d resp_k=%0d mem=%h, want 1/0/1/00",
                     er, wn, rk, mem[2041]);
        end
    endtask

    task automatic test_align();
        logic [63:0] rd; logic er; int rk, wk, wn;
        logic exp_err; int exp_k;
`ifdef LSU_ALIGN_CHECK_EN
        exp_err = 1'b1; exp_k = 1;
`else
        exp_err = 1'b0; exp_k = 2;
`endif
        do_access(1'b0, 2'd2, 1'b0, 64'd2, 64'd0, rd, er, rk, wk, wn);
        n_checks++;
        if (er !== exp_err || rk != exp_k || rd !== 64'd0) begin
            n_fail++;
            $display("FAIL align_word2: err=%b resp_k=%0d rdata=%h, want %b/%0d/0",
                     er, rk, rd, exp_err, exp_k);
        end
    endtask

    task automatic test_resp_hold();
        logic [63:0] r0; logic e0; int seen;
        seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd1; req_unsigned = 1'b1;
        req_addr = 64'd16; req_wdata = 64'd0;
        @(posedge clk);
        // req_valid stays high and fields change; nothing must be re-accepted.
        #1 req_addr = 64'd32;
        for (int k = 0; k < 20 && !resp_valid; k++) @(negedge clk);
        r0 = resp_rdata; e0 = resp_error;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (resp_valid && resp_rdata === r0 && resp_error === e0 && !req_ready) seen++;
        end
        n_checks++;
        if (seen != 3 || r0 !== 64'h0000_0000_0000_BEEF) begin
            n_fail++;
            $display("FAIL resp_hold: stable=%0d rdata=%h, want 3/000000000000beef", seen, r0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int rk;
        rk = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'd2044; req_wdata = 64'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        // Response handshake and a new request in the same cycle.
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 64'd0;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: ready=%b valid=%b, want 1/0", req_ready, resp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin rk = k; break; end
        end
        n_checks++;
        if (rk != 2 || resp_rdata !== 64'd8 || resp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: resp_k=%0d rdata=%h err=%b, want 2/8/0",
                     rk, resp_rdata, resp_error);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] rd; logic er; int rk, wk, wn;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 64'd24; req_wdata = 64'h1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_write: mem_write=%b, want 1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_write: wr=%b addr=%h wdata=%h valid=%b, want 0/0/0/0",
                     mem_write, mem_addr, mem_wdata, resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: req_ready=%b, want 1", req_ready);
        end
        do_access(1'b0, 2'd3, 1'b0, 64'd24, 64'd0, rd, er, rk, wk, wn);
        n_checks++;
        if (rd !== 64'd0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mem_unchanged: rdata=%h err=%b, want 0/0", rd, er);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[7] = 8'h08;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_load_double();
        test_store_half();
        test_extend();
        test_store_merge();
        test_range();
        test_align();
        test_resp_hold();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_LIMIT, 2048, byte size of the attached data memory.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  in  1  core access request valid.
REQ-005 SHALL have port: req_ready  out  1  unit idle and accepting a request.
REQ-006 SHALL have port: req_write  in  1  1=store, 0=load.
REQ-007 SHALL have port: req_size  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
REQ-008 SHALL have port: req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
REQ-009 SHALL have port: req_addr  in  64  byte address.
REQ-010 SHALL have port: req_wdata  in  64  store data, right-aligned (low n bytes used).
REQ-011 SHALL have port: resp_valid  out  1  response available.
REQ-012 SHALL have port: resp_ready  in  1  core accepts response.
REQ-013 SHALL have port: resp_rdata  out  64  extended load data; 0 for stores and errors.
REQ-014 SHALL have port: resp_error  out  1  access rejected, no memory effect.
REQ-015 SHALL have port: mem_addr  out  64  data-memory address; 0 in IDLE and RESP.
REQ-016 SHALL have port: mem_wdata  out  64  data-memory write word.
REQ-017 SHALL have port: mem_write  out  1  data-memory write strobe, write on next rising clk.
REQ-018 SHALL have port: mem_rdata  in  64  combinational data-memory read word.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL register the request fields on the req_valid && req_ready edge.
REQ-021 SHALL leave IDLE as follows: on error go to RESP; on store of size 3 go to WRITE; otherwise go to READ.
REQ-022 SHALL, in READ, drive mem_addr=addr and capture mem_rdata; next state is RESP for loads and WRITE for stores.
REQ-023 SHALL, in WRITE, assert mem_write for exactly one cycle with mem_addr=addr, then go to RESP.
REQ-024 SHALL use big-endian byte order: the byte at addr is mem_rdata[63:56]; an n-byte load takes mem_rdata[63:64-8n] and extends it per req_unsigned (size 3 is unextended).
REQ-025 SHALL, for a store, replace the top n bytes of the captured word with req_wdata[8n-1:0] and keep the remaining bytes unchanged; a size-3 store writes req_wdata directly.
REQ-026 SHALL flag a range error when addr > ADDR_LIMIT-8, because the memory always spans 8 bytes.
REQ-027 SHALL hold resp_valid and resp_rdata/resp_error stable in RESP until resp_ready, then return to IDLE; resp_valid=1 only in RESP.
REQ-028 SHALL have these latencies from the accept edge T: load resp_valid at T+2; sub-double store mem_write at T+2 and resp_valid at T+3; double store mem_write at T+1 and resp_valid at T+2; error resp_valid at T+1.
REQ-029 SHALL ignore req_valid outside IDLE; with resp_valid && resp_ready and a new req_valid in the same cycle, the new request is accepted only on a later IDLE cycle.

Reset
REQ-030 SHALL, on rst_n low (including mid-access), go immediately to IDLE with mem_write=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_error=0, and req_ready=1 after release.

Configuration
REQ-031 SHALL, with LSU_ALIGN_CHECK_EN defined, flag an error when addr mod 2^size != 0, with no memory access.
REQ-032 SHALL, without LSU_ALIGN_CHECK_EN, perform misaligned accesses normally; the range check still applies.

Structure
REQ-033 SHALL place the size encoding, FSM state enum and default ADDR_LIMIT in shared package lsu_pkg.
REQ-034 SHALL place the combinational extract/extend/merge logic in sub-module lsu_align.

Verification
REQ-035 SHALL cover: memory bytes 0..7 = 00..00,08; load double addr 0 -> resp_rdata=64'd8 at T+2, resp_error=0.
REQ-036 SHALL cover: store half 16'hBEEF at addr 16 -> one mem_write at T+2; load double addr 16 -> 64'hBEEF_0000_0000_0000.
REQ-037 SHALL cover: load signed byte addr 16 after REQ-036 -> 64'hFFFF_FFFF_FFFF_FFBE; unsigned -> 64'h0000_0000_0000_00BE.
REQ-038 SHALL cover: load double addr 2044 -> resp_error=1 at T+1, mem_write never asserted, resp_rdata=0.
REQ-039 SHALL cover: load word addr 2 -> error with LSU_ALIGN_CHECK_EN; 64'h0 data (bytes 2..5) without it.
REQ-040 SHALL cover: rst_n low during WRITE -> mem_write drops that cycle; memory unchanged; req_ready=1 after release.
